cache_split2_fifo: RTL and testbench

//   Clocked 1-to-2 demultiplexer with per-branch skid buffering on the drive/free handshake.
//   A single upstream producer (e.g. the merged request stream) is routed to consumer 0 or 1 by i_sel.
//   It is the fan-out counterpart of the 2-to-1 mutex merge in the cache control path.
//   It also keeps saturating per-branch delivery counters for debug/perf.

---
 rtl/cache_split2_fifo.sv | 75 +++++++
 tb/tb_cache_split2_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cache_split2_fifo.sv
// cache_split2_fifo: clocked 1-to-2 demux with a 2-deep skid buffer per branch and saturating delivery counters
//   clk, rst                 clock, asynchronous active-high reset
//   i_drive/i_data/i_sel     upstream beat and route select; o_free is the registered upstream ready
//   o_drive0/o_data0/i_free0 branch-0 handshake
//   o_drive1/o_data1/i_free1 branch-1 handshake
//   o_cnt0/o_cnt1            per-branch delivered-beat counters, saturating
module cache_split2_fifo #(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_drive,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_sel,
  output logic              o_free,
  output logic              o_drive0,
  output logic [DATA_W-1:0] o_data0,
  input  logic              i_free0,
  output logic              o_drive1,
  output logic [DATA_W-1:0] o_data1,
  input  logic              i_free1,
  output logic [CNT_W-1:0]  o_cnt0,
  output logic [CNT_W-1:0]  o_cnt1
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} st_t;
  st_t               st_q   [2];
  st_t               st_d   [2];
  logic [DATA_W-1:0] out_q  [2];
  logic [DATA_W-1:0] out_d  [2];
  logic [DATA_W-1:0] skid_q [2];
  logic [DATA_W-1:0] skid_d [2];
  logic [CNT_W-1:0]  cnt_q  [2];
  logic [CNT_W-1:0]  cnt_d  [2];
  logic              free_q, free_d, acc;
  logic [1:0]        in_v, rdy_v, drv_v, del_v;
  assign acc   = i_drive & free_q;
  assign in_v  = {acc & i_sel, acc & ~i_sel};
  assign rdy_v = {i_free1, i_free0};
  assign drv_v = {st_q[1] != EMPTY, st_q[0] != EMPTY};
  assign del_v = drv_v & rdy_v;
  // State encoding doubles as occupancy, so next state is simply occupancy + in - del.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      st_d[k]   = st_t'(st_q[k] + {1'b0, in_v[k]} - {1'b0, del_v[k]});
      out_d[k]  = (in_v[k] & ((st_q[k] == EMPTY) | del_v[k])) ? i_data :
                  ((st_q[k] == TWO) & del_v[k]) ? skid_q[k] : out_q[k];
      skid_d[k] = (in_v[k] & (st_q[k] == ONE) & ~del_v[k]) ? i_data : skid_q[k];
      cnt_d[k]  = (del_v[k] & ~&cnt_q[k]) ? cnt_q[k] + 1'b1 : cnt_q[k];
    end
    free_d = (st_d[0] != TWO) & (st_d[1] != TWO);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= '{EMPTY, EMPTY};
      out_q  <= '{default: '0};
      skid_q <= '{default: '0};
      cnt_q  <= '{default: '0};
      free_q <= 1'b1;
    end else begin
      st_q   <= st_d;
      out_q  <= out_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
      free_q <= free_d;
    end
  end
  assign o_free   = free_q;
  assign o_drive0 = drv_v[0];
  assign o_drive1 = drv_v[1];
  assign o_data0  = out_q[0];
  assign o_data1  = out_q[1];
  assign o_cnt0   = cnt_q[0];
  assign o_cnt1   = cnt_q[1];
endmodule

// File: tb/tb_cache_split2_fifo.sv
// tb_cache_split2_fifo: directed and randomized checks of cache_split2_fifo against a queue-based model
module tb_cache_split2_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic       drv, sel, f0, f1;
  logic [7:0] dat;
  logic       free, d0, d1;
  logic [7:0] q0d, q1d, c0, c1;
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  int         mc0, mc1;
  bit         mfree, last_acc;
  int         checks = 0;
  int         failures = 0;

  cache_split2_fifo #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i_drive(drv), .i_data(dat), .i_sel(sel), .o_free(free),
    .o_drive0(d0), .o_data0(q0d), .i_free0(f0),
    .o_drive1(d1), .o_data1(q1d), .i_free1(f1),
    .o_cnt0(c0), .o_cnt1(c1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    mc0 = 0;
    mc1 = 0;
    mfree = 1'b1;
    last_acc = 1'b0;
  endtask

  // Advance one clock: model the edge from the inputs currently applied, then wait for the next negedge.
  task automatic cyc();
    bit acc, e0, e1;
    acc = drv && mfree;
    e0 = (mq0.size() > 0) && f0;
    e1 = (mq1.size() > 0) && f1;
    if (e0) begin void'(mq0.pop_front()); if (mc0 < 255) mc0++; end
    if (e1) begin void'(mq1.pop_front()); if (mc1 < 255) mc1++; end
    if (acc) begin if (sel) mq1.push_back(dat); else mq0.push_back(dat); end
    mfree = (mq0.size() < 2) && (mq1.size() < 2);
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; drv = 0; sel = 0; dat = 0; f0 = 0; f1 = 0;
    #1;
    checks++; if (free !== 1'b1) begin failures++; $display("FAIL reset_free got=%0b exp=1", free); end
    checks++; if (d0 !== 1'b0 || d1 !== 1'b0) begin failures++; $display("FAIL reset_drive got=%0b%0b exp=00", d1, d0); end
    checks++; if (q0d !== 8'd0 || q1d !== 8'd0) begin failures++; $display("FAIL reset_data got=%0h/%0h exp=0/0", q0d, q1d); end
    checks++; if (c0 !== 8'd0 || c1 !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", c0, c1); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_stream();
    f0 = 1; f1 = 1;
    for (int i = 0; i < 8; i++) begin
      drv = 1; dat = 8'(i); sel = i[0];
      checks++; if (free !== 1'b1) begin failures++; $display("FAIL stream_free beat=%0d got=%0b exp=1", i, free); end
      cyc();
      checks++;
      if (sel == 1'b0 ? (d0 !== 1'b1 || q0d !== 8'(i)) : (d1 !== 1'b1 || q1d !== 8'(i))) begin
        failures++; $display("FAIL stream_out beat=%0d got d0=%0b q0=%0d d1=%0b q1=%0d exp=%0d on branch %0b", i, d0, q0d, d1, q1d, i, sel);
      end
    end
    drv = 0;
    cyc();
    checks++; if (c0 !== 8'd4 || c1 !== 8'd4) begin failures++; $display("FAIL stream_cnt got=%0d/%0d exp=4/4", c0, c1); end
    checks++; if (d0 !== 1'b0 || d1 !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0b%0b exp=00", d1, d0); end
  endtask

  task automatic test_stall();
    f0 = 0; drv = 1; sel = 0; dat = 8'hA5;
    cyc();
    checks++; if (d0 !== 1'b1 || q0d !== 8'hA5 || free !== 1'b1) begin failures++; $display("FAIL stall_first got d0=%0b q0=%0h free=%0b exp=1/a5/1", d0, q0d, free); end
    dat = 8'h5A;
    cyc();
    drv = 0;
    checks++; if (d0 !== 1'b1 || q0d !== 8'hA5 || free !== 1'b0) begin failures++; $display("FAIL stall_full got d0=%0b q0=%0h free=%0b exp=1/a5/0", d0, q0d, free); end
    cyc();
    checks++; if (d0 !== 1'b1 || q0d !== 8'hA5 || free !== 1'b0) begin failures++; $display("FAIL stall_hold got d0=%0b q0=%0h free=%0b exp=1/a5/0", d0, q0d, free); end
    f0 = 1;
    cyc();
    checks++; if (d0 !== 1'b1 || q0d !== 8'h5A || free !== 1'b1) begin failures++; $display("FAIL stall_skid got d0=%0b q0=%0h free=%0b exp=1/5a/1", d0, q0d, free); end
    cyc();
    checks++; if (d0 !== 1'b0 || c0 !== 8'd6) begin failures++; $display("FAIL stall_done got d0=%0b cnt0=%0d exp=0/6", d0, c0); end
  endtask

  task automatic test_block();
    f0 = 0; f1 = 1; drv = 1; sel = 0; dat = 8'hC1;
    cyc();
    dat = 8'hD2;
    cyc();
    sel = 1; dat = 8'hE3;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (free !== 1'b0 || d1 !== 1'b0) begin failures++; $display("FAIL block_wait%0d got free=%0b d1=%0b exp=0/0", i, free, d1); end
    end
    f0 = 1;
    cyc();
    checks++; if (free !== 1'b1 || d1 !== 1'b0 || q0d !== 8'hD2) begin failures++; $display("FAIL block_release got free=%0b d1=%0b q0=%0h exp=1/0/d2", free, d1, q0d); end
    cyc();
    dat = 8'hF4;
    checks++; if (d1 !== 1'b1 || q1d !== 8'hE3) begin failures++; $display("FAIL block_first got d1=%0b q1=%0h exp=1/e3", d1, q1d); end
    cyc();
    drv = 0;
    checks++; if (d1 !== 1'b1 || q1d !== 8'hF4) begin failures++; $display("FAIL block_second got d1=%0b q1=%0h exp=1/f4", d1, q1d); end
    cyc();
    checks++; if (c0 !== 8'd8 || c1 !== 8'd6) begin failures++; $display("FAIL block_cnt got=%0d/%0d exp=8/6", c0, c1); end
  endtask

  task automatic test_async_reset();
    f0 = 0; f1 = 0; drv = 1; sel = 0; dat = 8'h11;
    cyc();
    sel = 1; dat = 8'h22;
    cyc();
    sel = 0; dat = 8'h33;
    cyc();
    drv = 0;
    checks++; if (free !== 1'b0 || d0 !== 1'b1 || d1 !== 1'b1) begin failures++; $display("FAIL areset_pre got free=%0b d0=%0b d1=%0b exp=0/1/1", free, d0, d1); end
    #2 rst = 1'b1;
    #1;
    checks++; if (d0 !== 1'b0 || d1 !== 1'b0 || free !== 1'b1) begin failures++; $display("FAIL areset_out got d0=%0b d1=%0b free=%0b exp=0/0/1", d0, d1, free); end
    checks++; if (c0 !== 8'd0 || c1 !== 8'd0) begin failures++; $display("FAIL areset_cnt got=%0d/%0d exp=0/0", c0, c1); end
    checks++; if (q0d !== 8'd0 || q1d !== 8'd0) begin failures++; $display("FAIL areset_data got=%0h/%0h exp=0/0", q0d, q1d); end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_saturate();
    f0 = 1; f1 = 1; drv = 1; sel = 1;
    for (int i = 0; i < 259; i++) begin
      dat = 8'($urandom);
      cyc();
    end
    drv = 0;
    cyc();
    checks++; if (c1 !== 8'd255) begin failures++; $display("FAIL sat_cnt1 got=%0d exp=255", c1); end
    checks++; if (c0 !== 8'd0) begin failures++; $display("FAIL sat_cnt0 got=%0d exp=0", c0); end
  endtask

  task automatic test_random();
    int pr = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!(drv && !last_acc)) begin
        drv = ($urandom_range(0, 3) != 0);
        sel = 1'($urandom);
        dat = 8'($urandom);
      end
      f0 = ($urandom_range(0, 9) < 7);
      f1 = ($urandom_range(0, 9) < 6);
      checks++;
      if (d0 !== (mq0.size() > 0) || (d0 === 1'b1 && q0d !== mq0[0])) begin
        failures++; if (pr++ < 10) $display("FAIL rand_b0 cyc=%0d got d0=%0b q0=%0h exp d0=%0b q0=%0h", i, d0, q0d, mq0.size() > 0, mq0.size() > 0 ? mq0[0] : 8'h0);
      end
      checks++;
      if (d1 !== (mq1.size() > 0) || (d1 === 1'b1 && q1d !== mq1[0])) begin
        failures++; if (pr++ < 10) $display("FAIL rand_b1 cyc=%0d got d1=%0b q1=%0h exp d1=%0b q1=%0h", i, d1, q1d, mq1.size() > 0, mq1.size() > 0 ? mq1[0] : 8'h0);
      end
      checks++;
      if (free !== mfree || c0 !== 8'(mc0) || c1 !== 8'(mc1)) begin
        failures++; if (pr++ < 10) $display("FAIL rand_ctl cyc=%0d got free=%0b cnt=%0d/%0d exp free=%0b cnt=%0d/%0d", i, free, c0, c1, mfree, mc0, mc1);
      end
      cyc();
    end
    drv = 0; f0 = 1; f1 = 1;
    cyc();
    cyc();
    cyc();
    checks++; if (d0 !== 1'b0 || d1 !== 1'b0 || free !== 1'b1) begin failures++; $display("FAIL rand_drain got d0=%0b d1=%0b free=%0b exp=0/0/1", d0, d1, free); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_block();
    test_async_reset();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
